// File: rtl/x_dl_capture_ctrl.sv
// ----------------------------------------------------------------------------
// x_dl_capture_ctrl
//
// Command sequencer that sits between the UART byte streams and the delay-line
// tap vector. Single-byte commands arrive from the UART receiver. The tap
// vector i_dl is captured through a free-running synchroniser into a snapshot
// register. The block then returns either the raw snapshot (LSB byte first) or
// its popcount to the UART transmitter over a valid/accept handshake.
//
//   'S' (0x53) : snapshot, send P_DW/8 raw bytes, LSB byte first
//   'P' (0x50) : snapshot, send popcount(snapshot) as one byte
//   'R' (0x52) : keep repeating 'P' until any further rx byte terminates it
//   other      : send a single 0x3F, no snapshot
//
// Ports
//   i_clk     in   1     clock
//   i_rst_n   in   1     reset, asynchronous assert, active low
//   i_valid   in   1     rx byte strobe, one cycle per byte
//   i_data    in   8     rx byte, qualified by i_valid
//   o_valid   out  1     tx byte available
//   i_accept  in   1     tx sink takes the byte when o_valid & i_accept
//   o_data    out  8     tx byte
//   i_dl      in   P_DW  delay-line taps, asynchronous to i_clk
//   o_busy    out  1     high whenever the FSM is not in IDLE
//   o_drop    out  1     one-cycle pulse: rx byte discarded
// ----------------------------------------------------------------------------
module x_dl_capture_ctrl #(
    parameter int P_DW   = 32,  // multiple of 8, 8..248
    parameter int P_SYNC = 2    // synchroniser depth, >= 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [7:0]      i_data,
    output logic            o_valid,
    input  logic            i_accept,
    output logic [7:0]      o_data,
    input  logic [P_DW-1:0] i_dl,
    output logic            o_busy,
    output logic            o_drop
);

    localparam int NB = P_DW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(P_SYNC);

    localparam logic [7:0] CMD_SNAP   = 8'h53;
    localparam logic [7:0] CMD_POP    = 8'h50;
    localparam logic [7:0] CMD_REPEAT = 8'h52;
    localparam logic [7:0] ERR_BYTE   = 8'h3F;

    typedef enum logic [1:0] {ST_IDLE, ST_CAP, ST_SEND} state_t;
    typedef enum logic [1:0] {MD_RAW, MD_POP, MD_ERR}   mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q,  mode_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic              rep_q,   rep_d;
    logic              term_q,  term_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q,  data_d;
    logic [P_DW-1:0]   snap_q,  snap_d;
    logic [P_DW-1:0]   sync_q [P_SYNC];
    logic [P_DW-1:0]   sync_d [P_SYNC];

    logic [7:0]        pop_cnt;
    logic [IW-1:0]     idx_nxt;
    logic [7:0]        byte_cur;
    logic [7:0]        byte_nxt;
    logic              last_byte;
    logic              rx_busy;
    logic              term_hit;
    logic              term_now;
    logic              drop_c;

    // ------------------------------------------------------------------
    // Free-running synchroniser on the asynchronous tap vector.
    // ------------------------------------------------------------------
    always_comb begin
        sync_d[0] = i_dl;
        for (int i = 1; i < P_SYNC; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Popcount of the snapshot; P_DW <= 248 keeps the result inside 8 bits.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < P_DW; i++) begin
            pop_cnt = pop_cnt + 8'(snap_q[i]);
        end
    end

    assign idx_nxt   = idx_q + IW'(1);
    assign byte_cur  = snap_q[{idx_q, 3'b000} +: 8];
    assign byte_nxt  = snap_q[{idx_nxt, 3'b000} +: 8];
    assign last_byte = (mode_q != MD_RAW) || (idx_q == IW'(NB - 1));

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        term_d  = term_q;
        valid_d = valid_q;
        data_d  = data_q;
        snap_d  = snap_q;

        // A byte arriving while busy is either the repeat terminator (first
        // one only) or a discard.
        rx_busy  = i_valid && (state_q != ST_IDLE);
        term_hit = rx_busy && rep_q && !term_q;
        drop_c   = rx_busy && !term_hit;
        term_now = term_q || term_hit;
        if (term_hit) begin
            term_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    cnt_d  = '0;
                    idx_d  = '0;
                    rep_d  = 1'b0;
                    term_d = 1'b0;
                    case (i_data)
                        CMD_SNAP: begin
                            mode_d  = MD_RAW;
                            state_d = ST_CAP;
                        end
                        CMD_POP: begin
                            mode_d  = MD_POP;
                            state_d = ST_CAP;
                        end
                        CMD_REPEAT: begin
                            mode_d  = MD_POP;
                            rep_d   = 1'b1;
                            state_d = ST_CAP;
                        end
                        default: begin
                            mode_d  = MD_ERR;
                            state_d = ST_SEND;
                        end
                    endcase
                end
            end

            ST_CAP: begin
                // Wait out the synchroniser so the snapshot reflects taps
                // sampled no earlier than the command cycle.
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(P_SYNC - 1)) begin
                    cnt_d   = '0;
                    snap_d  = sync_q[P_SYNC-1];
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!valid_q) begin
                    // First cycle in SEND: snapshot is now settled, present
                    // the first byte.
                    valid_d = 1'b1;
                    unique case (mode_q)
                        MD_RAW:  data_d = byte_cur;
                        MD_POP:  data_d = pop_cnt;
                        default: data_d = ERR_BYTE;
                    endcase
                end else if (i_accept) begin
                    if (last_byte) begin
                        valid_d = 1'b0;
                        idx_d   = '0;
                        if (rep_q && !term_now) begin
                            state_d = ST_CAP;
                        end else begin
                            state_d = ST_IDLE;
                            rep_d   = 1'b0;
                            term_d  = 1'b0;
                        end
                    end else begin
                        // Only raw mode has more than one byte; keep o_valid
                        // high so back-to-back accepts run at 1 byte/cycle.
                        idx_d  = idx_nxt;
                        data_d = byte_nxt;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MD_RAW;
            cnt_q   <= '0;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            term_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            snap_q  <= '0;
            for (int i = 0; i < P_SYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            term_q  <= term_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            snap_q  <= snap_d;
            for (int i = 0; i < P_SYNC; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_drop  = drop_c;

endmodule

// File: tb/tb_x_dl_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_x_dl_capture_ctrl
//
// Directed bench for x_dl_capture_ctrl. Expected tx bytes are pushed into a
// queue when a command is issued and popped as the DUT presents each byte.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_x_dl_capture_ctrl;

    localparam int P_DW   = 32;
    localparam int P_SYNC = 2;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_valid;
    logic [7:0]      i_data;
    logic            o_valid;
    logic            i_accept;
    logic [7:0]      o_data;
    logic [P_DW-1:0] i_dl;
    logic            o_busy;
    logic            o_drop;

    int compared   = 0;
    int mismatched = 0;
    int drop_seen  = 0;

    logic [7:0] exp_q [$];

    x_dl_capture_ctrl #(.P_DW(P_DW), .P_SYNC(P_SYNC)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_accept (i_accept),
        .o_data   (o_data),
        .i_dl     (i_dl),
        .o_busy   (o_busy),
        .o_drop   (o_drop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one rx byte for one cycle; report o_drop in that cycle.
    task automatic send_cmd(input logic [7:0] b, output logic drop);
        i_valid = 1'b1;
        i_data  = b;
        #1 drop = o_drop;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    // Receive n bytes against the scoreboard. Optionally stall on byte stall_k
    // for stall_n cycles, and inject rx byte inj_b while byte inj_k is offered.
    task automatic recv(input int n, input int stall_k, input int stall_n,
                        input int inj_k, input logic [7:0] inj_b, input string tag);
        logic [7:0] e;
        int w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (o_valid !== 1'b1 && w < 50) begin
                i_accept = 1'b0;
                @(negedge i_clk);
                w++;
            end
            if (o_valid !== 1'b1) begin
                check($sformatf("%s byte%0d timeout", tag, k), 32'(o_valid), 32'd1);
                i_accept = 1'b0;
                return;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            if (k == stall_k) begin
                i_accept = 1'b0;
                repeat (stall_n) begin
                    @(negedge i_clk);
                    check($sformatf("%s stall valid", tag), 32'(o_valid), 32'd1);
                    check($sformatf("%s stall data", tag), 32'(o_data), 32'(e));
                end
            end
            if (k == inj_k) begin
                i_valid = 1'b1;
                i_data  = inj_b;
                #1 if (o_drop) drop_seen++;
            end
            check($sformatf("%s byte%0d", tag, k), 32'(o_data), 32'(e));
            i_accept = 1'b1;
            @(negedge i_clk);
            i_valid = 1'b0;
            i_data  = 8'h00;
        end
        i_accept = 1'b0;
    endtask

    // Confirm the sequence is over: no further bytes, idle, scoreboard drained.
    task automatic expect_idle(input int cyc, input string tag);
        int v = 0;
        repeat (cyc) begin
            @(negedge i_clk);
            if (o_valid) v++;
        end
        check({tag, " extra bytes"}, 32'(v), 32'd0);
        check({tag, " busy"}, 32'(o_busy), 32'd0);
        check({tag, " queue left"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] t2_dl  [3] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00000000};
    logic [7:0]  t2_exp [3] = '{8'h10, 8'h20, 8'h00};

    initial begin
        logic d;
        int   lat;
        int   w;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_data   = 8'h00;
        i_accept = 1'b0;
        i_dl     = '0;
        repeat (3) @(negedge i_clk);
        check("reset o_valid", 32'(o_valid), 32'd0);
        check("reset o_data",  32'(o_data),  32'd0);
        check("reset o_busy",  32'(o_busy),  32'd0);
        check("reset o_drop",  32'(o_drop),  32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 1: raw snapshot with a long stall on byte 1.
        i_dl = 32'h12345678;
        repeat (4) @(negedge i_clk);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        send_cmd(8'h53, d);
        check("t1 cmd drop", 32'(d), 32'd0);
        check("t1 busy", 32'(o_busy), 32'd1);
        recv(4, 1, 10, -1, 8'h00, "t1");
        expect_idle(8, "t1");

        // 2: popcount with latency measurement.
        for (int i = 0; i < 3; i++) begin
            i_dl = t2_dl[i];
            repeat (3) @(negedge i_clk);
            exp_q.push_back(t2_exp[i]);
            send_cmd(8'h50, d);
            lat = 1;
            while (o_valid !== 1'b1 && lat < 50) begin
                @(negedge i_clk);
                lat++;
            end
            check($sformatf("t2 latency %0d", i), 32'(lat), 32'(P_SYNC + 2));
            recv(1, -1, 0, -1, 8'h00, $sformatf("t2.%0d", i));
            expect_idle(3, "t2");
        end

        // 3: unknown command; tap changes are irrelevant.
        exp_q.push_back(8'h3F);
        send_cmd(8'h41, d);
        i_dl = 32'hDEADBEEF;
        recv(1, -1, 0, -1, 8'h00, "t3");
        expect_idle(6, "t3");

        // 4: repeat mode terminated while capturing the fourth snapshot.
        i_dl = 32'h000000FF;
        repeat (3) @(negedge i_clk);
        repeat (4) exp_q.push_back(8'h08);
        drop_seen = 0;
        send_cmd(8'h52, d);
        check("t4 cmd drop", 32'(d), 32'd0);
        recv(3, -1, 0, -1, 8'h00, "t4a");
        check("t4 busy before term", 32'(o_busy), 32'd1);
        send_cmd(8'h00, d);
        check("t4 term drop", 32'(d), 32'd0);
        recv(1, -1, 0, -1, 8'h00, "t4b");
        expect_idle(12, "t4");
        check("t4 drop count", 32'(drop_seen), 32'd0);

        i_dl = 32'hA1B2C3D4;
        repeat (3) @(negedge i_clk);
        exp_q.push_back(8'hD4); exp_q.push_back(8'hC3);
        exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
        send_cmd(8'h53, d);
        recv(4, -1, 0, -1, 8'h00, "t4s");
        expect_idle(6, "t4s");

        // 5: rx byte injected mid-stream is discarded.
        i_dl = 32'h12345678;
        repeat (3) @(negedge i_clk);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        drop_seen = 0;
        send_cmd(8'h53, d);
        recv(4, -1, 0, 2, 8'h50, "t5");
        check("t5 drop count", 32'(drop_seen), 32'd1);
        expect_idle(12, "t5");

        // 6: asynchronous reset while a byte is offered.
        send_cmd(8'h53, d);
        w = 0;
        while (o_valid !== 1'b1 && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        check("t6 valid before reset", 32'(o_valid), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("t6 reset o_valid", 32'(o_valid), 32'd0);
        check("t6 reset o_busy",  32'(o_busy),  32'd0);
        check("t6 reset o_data",  32'(o_data),  32'd0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_dl = 32'h0F0F0F0F;
        repeat (3) @(negedge i_clk);
        exp_q.push_back(8'h10);
        send_cmd(8'h50, d);
        recv(1, -1, 0, -1, 8'h00, "t6");
        expect_idle(6, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
